// File: rtl/fetch_stage_pkg.sv
// Shared constants and next-PC select encoding for the fetch stage.
// Imported by fetch_stage and if_id_reg.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR      = 32'd4;

  typedef enum logic [1:0] {
    NPC_SEL_PC4    = 2'd0,
    NPC_SEL_HOLD   = 2'd1,
    NPC_SEL_BRANCH = 2'd2,
    NPC_SEL_JUMP   = 2'd3
  } npc_sel_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush > squash > stall > load.
// Latency: 1 cycle. Backpressure: stall holds every field.
// Squashed slots keep the old pc4 so only instr/valid change.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        squash,
  input  logic [31:0] instr,
  input  logic [31:0] pc4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr <= NOP_INSTR;
      id_pc4   <= 32'h0000_0000;
      id_valid <= 1'b0;
    end else if (flush || squash) begin
      // flush and squash differ only in priority, not in effect
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_instr <= instr;
      id_pc4   <= pc4;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC select, IF/ID register, sticky misalign flag.
// Latency: 1 cycle instr_in -> id_instr. Backpressure: stall holds PC and IF/ID; redirects override stall.
// BRANCH_DELAY_SLOT_EN: redirects keep the IF instruction as a delay slot instead of squashing it.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        flush,
  output logic [31:0] next_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        misalign_err
);

  logic [31:0] pc4;
  logic [31:0] raw_target;
  logic        redirect;
  logic        squash;
  logic        if_stall;
  npc_sel_t    sel;

  assign pc4      = pc + PC_INCR;
  assign redirect = jump | branch_taken;

  always_comb begin
    sel = NPC_SEL_PC4;
    if (jump)              sel = NPC_SEL_JUMP;
    else if (branch_taken) sel = NPC_SEL_BRANCH;
    else if (stall)        sel = NPC_SEL_HOLD;
  end

  assign raw_target = (sel == NPC_SEL_JUMP) ? jump_target : branch_target;

  always_comb begin
    next_pc = pc4;
    if (rst) begin
      next_pc = RESET_VECTOR;
    end else begin
      case (sel)
        NPC_SEL_JUMP,
        NPC_SEL_BRANCH: next_pc = word_align(raw_target);
        NPC_SEL_HOLD:   next_pc = pc;
        default:        next_pc = pc4;
      endcase
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  // PC moves on a redirect, so the delay slot must load even under stall
  assign squash   = 1'b0;
  assign if_stall = stall & ~redirect;
`else
  assign squash   = redirect;
  assign if_stall = stall;
`endif

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .stall    (if_stall),
    .flush    (flush),
    .squash   (squash),
    .instr    (instr_in),
    .pc4      (pc4),
    .id_instr (id_instr),
    .id_pc4   (id_pc4),
    .id_valid (id_valid)
  );

  always_ff @(posedge clk) begin
    if (rst)
      misalign_err <= 1'b0;
    else if (redirect && (raw_target[1:0] != 2'b00))
      misalign_err <= 1'b1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus reset sequences.
module tb_fetch_stage;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, instr_in, branch_target, jump_target;
  logic        stall, branch_taken, jump, flush;
  logic [31:0] next_pc, id_instr, id_pc4;
  logic        id_valid, misalign_err;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .instr_in      (instr_in),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .flush         (flush),
    .next_pc       (next_pc),
    .id_instr      (id_instr),
    .id_pc4        (id_pc4),
    .id_valid      (id_valid),
    .misalign_err  (misalign_err)
  );

  typedef struct {
    logic [31:0] pc, instr;
    logic        stall, br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        fl;
    logic [31:0] e_npc, e_instr, e_pc4;
    logic        e_vld, e_mis;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] p, input logic [31:0] in, input logic s, input logic b,
    input logic [31:0] bt, input logic j, input logic [31:0] jt, input logic f,
    input logic [31:0] enpc, input logic [31:0] ein, input logic [31:0] ep4,
    input logic ev, input logic em);
    vec_t v;
    v.pc = p; v.instr = in; v.stall = s; v.br = b; v.bt = bt; v.j = j; v.jt = jt;
    v.fl = f; v.e_npc = enpc; v.e_instr = ein; v.e_pc4 = ep4; v.e_vld = ev; v.e_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pc = v.pc; instr_in = v.instr; stall = v.stall; branch_taken = v.br;
    branch_target = v.bt; jump = v.j; jump_target = v.jt; flush = v.fl;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ei,
                            input logic [31:0] ep, input logic ev, input logic em);
    chk({tag, ".id_instr"}, id_instr, ei);
    chk({tag, ".id_pc4"}, id_pc4, ep);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, ev});
    chk({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, em});
  endtask

  vec_t tv[$];

  initial begin
    // pc, instr, stall, br, bt, j, jt, flush | next_pc, id_instr, id_pc4, id_valid, misalign
    tv.push_back(mk(32'h0, 32'h20080005, 0, 0, 0, 0, 0, 0, 32'h4, 32'h20080005, 32'h4, 1, 0));
    tv.push_back(mk(32'h4, 32'h11111111, 0, 0, 0, 0, 0, 0, 32'h8, 32'h11111111, 32'h8, 1, 0));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(32'h100, 32'hAAAA0001, 1, 0, 0, 0, 0, 0, 32'h100, 32'h11111111, 32'h8, 1, 0));
    tv.push_back(mk(32'h100, 32'hAAAA0001, 0, 0, 0, 0, 0, 0, 32'h104, 32'hAAAA0001, 32'h104, 1, 0));
    tv.push_back(mk(32'h200, 32'hBBBB0002, 1, 1, 32'h400, 0, 0, 0, 32'h400,
                    DS ? 32'hBBBB0002 : 32'h0, DS ? 32'h204 : 32'h104, DS, 0));
    tv.push_back(mk(32'h300, 32'hCCCC0003, 0, 1, 32'h400, 1, 32'h800, 0, 32'h800,
                    DS ? 32'hCCCC0003 : 32'h0, DS ? 32'h304 : 32'h104, DS, 0));
    tv.push_back(mk(32'hFFFFFFFC, 32'hDDDD0004, 0, 0, 0, 0, 0, 0, 32'h0, 32'hDDDD0004, 32'h0, 1, 0));
    tv.push_back(mk(32'h10, 32'hEEEE0005, 1, 0, 0, 0, 0, 1, 32'h10, 32'h0, 32'h0, 0, 0));
    tv.push_back(mk(32'h10, 32'hEEEE0005, 0, 0, 0, 0, 0, 0, 32'h14, 32'hEEEE0005, 32'h14, 1, 0));
    tv.push_back(mk(32'h14, 32'h12345678, 0, 0, 0, 0, 0, 1, 32'h18, 32'h0, 32'h14, 0, 0));
    tv.push_back(mk(32'h20, 32'h0F0F0F0F, 0, 1, 32'h402, 0, 0, 0, 32'h400,
                    DS ? 32'h0F0F0F0F : 32'h0, DS ? 32'h24 : 32'h14, DS, 1));
    tv.push_back(mk(32'h400, 32'h22220006, 0, 0, 0, 0, 0, 0, 32'h404, 32'h22220006, 32'h404, 1, 1));
    tv.push_back(mk(32'h404, 32'h33330007, 0, 0, 0, 1, 32'h803, 0, 32'h800,
                    DS ? 32'h33330007 : 32'h0, DS ? 32'h408 : 32'h404, DS, 1));

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst.next_pc", next_pc, 32'h0);
    @(negedge clk);
    check_ifid("rst", 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d.next_pc", i), next_pc, tv[i].e_npc);
      @(posedge clk);
      #1;
      check_ifid($sformatf("v%0d", i), tv[i].e_instr, tv[i].e_pc4, tv[i].e_vld, tv[i].e_mis);
      @(negedge clk);
    end

    // reset arriving mid-stall and mid-redirect must forget everything
    rst = 1'b1;
    drive(mk(32'h500, 32'h55550009, 1, 1, 32'h602, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rstmid.next_pc", next_pc, 32'h0);
    @(posedge clk);
    #1;
    check_ifid("rstmid", 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(32'h0, 32'h44440008, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("postrst.next_pc", next_pc, 32'h4);
    @(posedge clk);
    #1;
    check_ifid("postrst", 32'h44440008, 32'h4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  single rising-edge clock for all state.
REQ-002 rst  in  1  synchronous active-high reset, sampled only at posedge clk.
REQ-003 pc  in  32  current PC from the PC register.
REQ-004 instr_in  in  32  instruction-memory read data at address pc, combinational, same cycle.
REQ-005 stall  in  1  hazard unit hold request for IF and IF/ID.
REQ-006 branch_taken  in  1  resolved taken branch.
REQ-007 branch_target  in  32  taken-branch destination.
REQ-008 jump  in  1  jump redirect.
REQ-009 jump_target  in  32  jump destination.
REQ-010 flush  in  1  exception squash of IF/ID.
REQ-011 next_pc  out  32  value driven into the PC register's next-value input.
REQ-012 id_instr  out  32  registered instruction to ID.
REQ-013 id_pc4  out  32  registered pc+4 to ID.
REQ-014 id_valid  out  1  id_instr holds a live instruction.
REQ-015 misalign_err  out  1  sticky flag: a redirect target was not word aligned.

Function
REQ-016 pc4 SHALL equal pc + 4, modulo 2^32; 32'hFFFFFFFC SHALL wrap to 32'h00000000.
REQ-017 next_pc SHALL be combinational with priority jump -> jump_target, else branch_taken -> branch_target, else stall -> pc, else pc4.
REQ-018 A redirect SHALL override stall in the same cycle.
REQ-019 Redirect targets SHALL pass to next_pc with bits [1:0] forced to 00.
REQ-020 misalign_err SHALL set one cycle after a selected redirect target has bits [1:0] != 0, and SHALL clear only on rst.
REQ-021 IF/ID update priority, evaluated at each posedge:
- flush: id_instr=0, id_valid=0, id_pc4 held.
- else squash: id_instr=0, id_valid=0.
- else stall: all IF/ID fields held.
- else load: id_instr=instr_in, id_pc4=pc4, id_valid=1.
REQ-022 Squash SHALL be asserted when (jump or branch_taken) is high, subject to REQ-031/032.
REQ-023 Latency SHALL be one cycle from instr_in at the IF stage to id_instr.
REQ-024 stall held for N cycles SHALL keep pc and the IF/ID register constant for those N cycles, and the instruction SHALL appear exactly once when stall releases.
REQ-025 flush together with stall SHALL squash; flush wins.

Reset
REQ-026 During rst, next_pc SHALL be 32'h00000000.
REQ-027 At a posedge with rst high: id_instr=0, id_pc4=0, id_valid=0, misalign_err=0.
REQ-028 rst mid-stall or mid-redirect SHALL discard all pending state; no redirect SHALL be remembered across reset.
REQ-029 The first cycle after rst deasserts SHALL fetch from pc=0 and load id_valid=1 unless stalled.

Configuration
REQ-030 Macro BRANCH_DELAY_SLOT_EN SHALL select the MIPS delay-slot behaviour.
REQ-031 When defined: branch_taken and jump SHALL NOT squash; the IF instruction loads normally as the delay slot, and only flush squashes.
REQ-032 When undefined: branch_taken or jump SHALL squash the IF instruction per REQ-021.
REQ-033 Next-PC selection SHALL be identical in both builds.

Structure
REQ-034 Shared package SHALL hold NOP_INSTR (32'h0), RESET_VECTOR (32'h0), PC_INCR (4) and the next-PC select encoding.
REQ-035 Sub-module if_id_reg SHALL hold the IF/ID register with stall/flush/squash priority; next-PC muxing stays in fetch_stage.

Verification
REQ-036 rst high 2 cycles, then low, pc=0, instr_in=32'h20080005 -> next_pc=4; next cycle id_instr=32'h20080005, id_pc4=4, id_valid=1.
REQ-037 pc=32'h100, stall high 3 cycles -> next_pc=32'h100 for all 3 cycles; IF/ID unchanged; single load after release.
REQ-038 pc=32'h200, branch_taken=1, branch_target=32'h400, stall=1 -> next_pc=32'h400; id_valid=0 without macro, id_valid=1 with id_pc4=32'h204 with macro.
REQ-039 jump=1 to 32'h800 with branch_taken=1 to 32'h400 -> next_pc=32'h800.
REQ-040 pc=32'hFFFFFFFC -> next_pc=0 and id_pc4=0.
REQ-041 branch_target=32'h402 taken -> next_pc=32'h400; misalign_err=1 next cycle and held until rst.
